// File: rtl/i2s_rx_frame_ctrl.sv
// Master-mode I2S receiver: derives bck/lrck from mck, captures left/right samples
// with the one-bit I2S delay and hands complete stereo frames out over valid/ready.
module i2s_rx_frame_ctrl #(
    parameter int unsigned MCK_PER_BCK = 16,
    parameter int unsigned SAMPLE_W    = 24,
    parameter int unsigned SLOT_BITS   = 32
) (
    input  logic                mck,
    input  logic                reset,
    input  logic                en,
    input  logic                data_in,
    output logic                bck,
    output logic                lrck,
    output logic [SAMPLE_W-1:0] sample_left,
    output logic [SAMPLE_W-1:0] sample_right,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overrun,
    input  logic                overrun_clr,
    output logic                busy
);

    localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
    localparam int unsigned HALF_BCK   = MCK_PER_BCK / 2;
    localparam int unsigned DCNT_W     = $clog2(MCK_PER_BCK);
    localparam int unsigned BCNT_W     = $clog2(FRAME_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state;
    logic [DCNT_W-1:0]   dcnt;
    logic [DCNT_W-1:0]   dcnt_nxt;
    logic [BCNT_W-1:0]   bcnt;
    logic [BCNT_W-1:0]   bcnt_nxt;
    logic [BCNT_W-1:0]   slot_bit;
    logic [SAMPLE_W-1:0] shift_q;
    logic [SAMPLE_W-1:0] hold_q;
    logic [SAMPLE_W-1:0] shift_in;
    logic                frame_done;
    logic                active;
    logic                dcnt_wrap;
    logic                frame_last;
    logic                strobe;
    logic                in_right;
    logic                cap_bit;
    logic                last_bit;

    // Counter successors, slot decode and the mid-bit sample strobe.
    always_comb begin
        active     = (state != IDLE);
        dcnt_wrap  = (dcnt == DCNT_W'(MCK_PER_BCK - 1));
        frame_last = dcnt_wrap && (bcnt == BCNT_W'(FRAME_BITS - 1));
        dcnt_nxt   = dcnt_wrap ? '0 : dcnt + DCNT_W'(1);
        bcnt_nxt   = bcnt;
        if (dcnt_wrap) begin
            bcnt_nxt = (bcnt == BCNT_W'(FRAME_BITS - 1)) ? '0 : bcnt + BCNT_W'(1);
        end
        in_right = (bcnt >= BCNT_W'(SLOT_BITS));
        slot_bit = in_right ? bcnt - BCNT_W'(SLOT_BITS) : bcnt;
        strobe   = active && (dcnt == DCNT_W'(HALF_BCK - 1));
        cap_bit  = (slot_bit != '0) && (slot_bit <= BCNT_W'(SAMPLE_W));
        last_bit = (slot_bit == BCNT_W'(SAMPLE_W));
        shift_in = {shift_q[SAMPLE_W-2:0], data_in};
    end

    always_ff @(posedge mck) begin
        if (reset) begin
            state        <= IDLE;
            dcnt         <= '0;
            bcnt         <= '0;
            bck          <= 1'b0;
            lrck         <= 1'b0;
            shift_q      <= '0;
            hold_q       <= '0;
            frame_done   <= 1'b0;
            sample_left  <= '0;
            sample_right <= '0;
            out_valid    <= 1'b0;
            overrun      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // Start is immediate; stop waits for the frame boundary so no frame is cut short.
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (en) begin
                        state <= RUN;
                    end else if (frame_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Clock outputs follow the counter values that hold after this edge.
            if (active) begin
                dcnt <= dcnt_nxt;
                bcnt <= bcnt_nxt;
                bck  <= (dcnt_nxt >= DCNT_W'(HALF_BCK));
                lrck <= (bcnt_nxt >= BCNT_W'(SLOT_BITS));
            end else begin
                dcnt <= '0;
                bcnt <= '0;
                bck  <= 1'b0;
                lrck <= 1'b0;
            end

            if (strobe && cap_bit) begin
                shift_q <= shift_in;
            end
            if (strobe && last_bit) begin
                if (!in_right) begin
                    hold_q <= shift_in;
                end else begin
                    frame_done <= 1'b1;
                end
            end

            // A new frame always wins over a pending one; losing an untaken frame is overrun.
            if (frame_done) begin
                sample_left  <= hold_q;
                sample_right <= shift_q;
                out_valid    <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (frame_done && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_frame_ctrl.sv
// Bench for i2s_rx_frame_ctrl: frame-level reference model driven by the bench's own
// notion of frame position, plus table vectors and hand sequences for corner cases.
module tb_i2s_rx_frame_ctrl;

    localparam int MCK      = 4;
    localparam int HALF     = MCK / 2;
    localparam int SLOT     = 32;
    localparam int SW       = 24;
    localparam int FR       = MCK * 2 * SLOT;
    localparam int LOAD_POS = (SLOT + SW) * MCK + HALF;
    localparam int NV       = 5;

    logic          mck = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic          data_in = 1'b0;
    logic          out_ready = 1'b0;
    logic          overrun_clr = 1'b0;
    logic          bck, lrck, out_valid, overrun, busy;
    logic [SW-1:0] sample_left, sample_right;

    typedef struct {
        logic [SW-1:0] l;
        logic [SW-1:0] r;
        int            junk;
        logic [SW-1:0] exp_l;
        logic [SW-1:0] exp_r;
    } vec_t;

    vec_t vecs[NV];
    vec_t vq[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: position within the frame since the enable edge.
    bit            m_busy = 1'b0, m_stop = 1'b0, m_valid = 1'b0, m_ovr = 1'b0;
    int            m_pos = 0, m_loads = 0;
    logic [SW-1:0] m_l = '0, m_r = '0;
    logic [SW-1:0] cur_l = '0, cur_r = '0;
    int            cur_junk = 0;
    bit            cur_is_vec = 1'b0;
    logic [SW-1:0] got_l = '0, got_r = '0;
    int            vec_done = 0;

    int first_valid = -1;
    int bck_last = -1, bck_prev = -1, lrck_last = -1, lrck_prev = -1;
    logic bck_q = 1'b0, lrck_q = 1'b0;
    bit track = 1'b0;
    int gap_bad = 0, busy_low = 0;

    i2s_rx_frame_ctrl #(
        .MCK_PER_BCK(MCK),
        .SAMPLE_W   (SW),
        .SLOT_BITS  (SLOT)
    ) dut (
        .mck         (mck),
        .reset       (reset),
        .en          (en),
        .data_in     (data_in),
        .bck         (bck),
        .lrck        (lrck),
        .sample_left (sample_left),
        .sample_right(sample_right),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .busy        (busy)
    );

    always #5 mck = ~mck;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic void pick_frame();
        vec_t v;
        if (vq.size() > 0) begin
            v          = vq.pop_front();
            cur_l      = v.l;
            cur_r      = v.r;
            cur_junk   = v.junk;
            cur_is_vec = 1'b1;
        end else begin
            cur_l      = SW'($urandom);
            cur_r      = SW'($urandom);
            cur_junk   = 0;
            cur_is_vec = 1'b0;
        end
    endfunction

    // Serial bit the ADC presents for the current bit period of the frame.
    function automatic logic drive_bit();
        int            b, s;
        logic [SW-1:0] w;
        if (!m_busy) return 1'($urandom);
        b = m_pos / MCK;
        s = b % SLOT;
        w = (b >= SLOT) ? cur_r : cur_l;
        if (s >= 1 && s <= SW) return w[SW-s];
        if (cur_junk == 1) return 1'b1;
        if (cur_junk == 2) return 1'b0;
        return 1'($urandom);
    endfunction

    task automatic step();
        bit load, accept, ovr_set, newf, vec_load, last;
        load = 1'b0; newf = 1'b0; vec_load = 1'b0;
        if (reset) begin
            m_busy = 1'b0; m_stop = 1'b0; m_pos = 0;
            m_valid = 1'b0; m_ovr = 1'b0; m_l = '0; m_r = '0;
        end else begin
            load    = m_busy && (m_pos == LOAD_POS);
            accept  = m_valid && out_ready;
            ovr_set = load && m_valid && !accept;
            if (load) begin
                m_valid = 1'b1; m_l = cur_l; m_r = cur_r; m_loads++;
                vec_load = cur_is_vec;
            end else if (accept) begin
                m_valid = 1'b0;
            end
            if (ovr_set) m_ovr = 1'b1;
            else if (overrun_clr) m_ovr = 1'b0;
            if (!m_busy) begin
                if (en) begin
                    m_busy = 1'b1; m_stop = 1'b0; m_pos = 0; newf = 1'b1;
                end
            end else begin
                last = (m_pos == FR - 1);
                if (m_stop) begin
                    if (en) m_stop = 1'b0;
                    else if (last) m_busy = 1'b0;
                end else if (!en) begin
                    m_stop = 1'b1;
                end
                m_pos = (m_pos + 1) % FR;
                if (m_busy && m_pos == 0) newf = 1'b1;
            end
        end

        @(posedge mck);
        #1;
        cyc++;
        chk("bck",       32'(bck),          32'(m_busy && ((m_pos % MCK) >= HALF)));
        chk("lrck",      32'(lrck),         32'(m_busy && (m_pos >= SLOT * MCK)));
        chk("busy",      32'(busy),         32'(m_busy));
        chk("out_valid", 32'(out_valid),    32'(m_valid));
        chk("overrun",   32'(overrun),      32'(m_ovr));
        chk("sample_l",  32'(sample_left),  32'(m_l));
        chk("sample_r",  32'(sample_right), 32'(m_r));

        if (vec_load) begin
            got_l = sample_left;
            got_r = sample_right;
            vec_done++;
        end
        if (out_valid && first_valid < 0) first_valid = cyc;
        if (bck && !bck_q) begin
            if (track && bck_last >= 0 && (cyc - bck_last) != MCK) gap_bad++;
            bck_prev = bck_last;
            bck_last = cyc;
        end
        if (lrck && !lrck_q) begin
            lrck_prev = lrck_last;
            lrck_last = cyc;
        end
        if (track && !busy) busy_low++;
        bck_q  = bck;
        lrck_q = lrck;

        if (newf) pick_frame();
        data_in = drive_bit();
    endtask

    task automatic wait_pos(input int pos, input int bound, input string name);
        for (int n = 0; n < bound && m_pos != pos; n++) step();
        chk(name, 32'(m_pos), 32'(pos));
    endtask

    task automatic wait_vec(input int target, input string name);
        for (int n = 0; n < 3 * FR && vec_done < target; n++) step();
        chk(name, 32'(vec_done), 32'(target));
    endtask

    initial begin
        int en_cyc, base, n, thr;
        logic [SW-1:0] stop_l, stop_r;

        vecs[0] = '{l: 24'hA5C3F1, r: 24'h123456, junk: 0, exp_l: 24'hA5C3F1, exp_r: 24'h123456};
        vecs[1] = '{l: 24'h000000, r: 24'h000000, junk: 1, exp_l: 24'h000000, exp_r: 24'h000000};
        vecs[2] = '{l: 24'hFFFFFF, r: 24'h000001, junk: 2, exp_l: 24'hFFFFFF, exp_r: 24'h000001};
        vecs[3] = '{l: 24'h800000, r: 24'h7FFFFF, junk: 1, exp_l: 24'h800000, exp_r: 24'h7FFFFF};
        vecs[4] = '{l: 24'h5A5A5A, r: 24'hC3C3C3, junk: 1, exp_l: 24'h5A5A5A, exp_r: 24'hC3C3C3};

        // Reset state
        repeat (3) step();
        chk("rst_bck", 32'(bck), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);

        // Table vectors, consumer always ready
        reset = 1'b0;
        out_ready = 1'b1;
        vq.push_back(vecs[0]);
        en = 1'b1;
        en_cyc = cyc;
        for (int i = 0; i < NV; i++) begin
            if (i > 0) vq.push_back(vecs[i]);
            wait_vec(i + 1, "vec_wait");
            chk($sformatf("vec%0d_left", i),  32'(got_l), 32'(vecs[i].exp_l));
            chk($sformatf("vec%0d_right", i), 32'(got_r), 32'(vecs[i].exp_r));
        end
        chk("first_valid_latency", 32'(first_valid), 32'(en_cyc + 1 + LOAD_POS + 1));
        chk("bck_period",  32'(bck_last - bck_prev),   32'(MCK));
        chk("lrck_period", 32'(lrck_last - lrck_prev), 32'(FR));

        // Overrun: consumer stalls across two frames
        out_ready = 1'b0;
        base = m_loads;
        for (n = 0; n < 3 * FR && m_loads < base + 2; n++) step();
        chk("ovr_set", 32'(overrun), 32'd1);
        chk("ovr_valid", 32'(out_valid), 32'd1);
        chk("ovr_new_l", 32'(sample_left), 32'(cur_l));
        chk("ovr_new_r", 32'(sample_right), 32'(cur_r));
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'd0);

        // Acceptance coincident with frame completion
        wait_pos(LOAD_POS, FR + 8, "coinc_sync");
        out_ready = 1'b1;
        step();
        chk("coinc_ovr", 32'(overrun), 32'd0);
        chk("coinc_valid", 32'(out_valid), 32'd1);
        chk("coinc_l", 32'(sample_left), 32'(cur_l));
        step();
        chk("coinc_taken", 32'(out_valid), 32'd0);

        // Random data and back-pressure
        for (int f = 0; f < 6; f++) begin
            thr = (f % 3 == 0) ? 1 : ((f % 3 == 1) ? 128 : 255);
            for (int c = 0; c < FR; c++) begin
                out_ready   = ($urandom_range(0, 255) < thr);
                overrun_clr = ($urandom_range(0, 63) == 0);
                step();
            end
        end
        overrun_clr = 1'b0;

        // Stop at left bit 10: frame finishes and is delivered
        out_ready = 1'b1;
        wait_pos(10 * MCK, FR + 8, "stop_sync");
        stop_l = cur_l;
        stop_r = cur_r;
        en = 1'b0;
        n = 0;
        while (busy && n < 3 * FR) begin
            step();
            n++;
        end
        chk("stop_len", 32'(n), 32'(FR - 10 * MCK));
        chk("stop_l", 32'(sample_left), 32'(stop_l));
        chk("stop_r", 32'(sample_right), 32'(stop_r));
        repeat (8) step();
        chk("idle_bck", 32'(bck), 32'd0);
        chk("idle_lrck", 32'(lrck), 32'd0);

        // Re-raise en during drain: clocks continue without a gap
        en = 1'b1;
        wait_pos(100, FR + 8, "drain_sync");
        track = 1'b1;
        gap_bad = 0;
        busy_low = 0;
        bck_last = -1;
        en = 1'b0;
        repeat (50) step();
        en = 1'b1;
        repeat (300) step();
        track = 1'b0;
        chk("drain_bck_gap", 32'(gap_bad), 32'd0);
        chk("drain_busy_low", 32'(busy_low), 32'd0);

        // Reset at right bit 12 with a frame pending
        out_ready = 1'b0;
        for (n = 0; n < 2 * FR && !m_valid; n++) step();
        wait_pos((SLOT + 12) * MCK, FR + 8, "rst_sync");
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        step();
        chk("mid_rst_bck", 32'(bck), 32'd0);
        chk("mid_rst_lrck", 32'(lrck), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ovr", 32'(overrun), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_l", 32'(sample_left), 32'd0);
        chk("mid_rst_r", 32'(sample_right), 32'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        vq.push_back('{l: 24'hABCDEF, r: 24'hFEDCBA, junk: 1, exp_l: 24'hABCDEF, exp_r: 24'hFEDCBA});
        wait_vec(vec_done + 1, "restart_wait");
        chk("restart_l", 32'(got_l), 32'h00ABCDEF);
        chk("restart_r", 32'(got_r), 32'h00FEDCBA);
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
